interrupt_controller: RTL
=========================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 15, number of interrupt sources.
REQ-002 SHALL have parameter EDGE_MASK, default all ones (NUM_CHANNELS bits), per channel 1=rising-edge trigger, 0=level trigger.
REQ-003 SHALL have parameter HOLDOFF_CYCLES, default 2, idle cycles after acknowledge before next request.
REQ-004 SHALL have derived localparam VEC_W = max(1, clog2(NUM_CHANNELS)).
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 irq_in  input  NUM_CHANNELS  raw interrupt sources, synchronous to clk.
REQ-009 irq_mask  input  NUM_CHANNELS  1=channel enabled to request.
REQ-010 interrupt_enable  input  1  CPU I flag; 0 blocks new requests.
REQ-011 irq_ack  input  1  single-cycle pulse, CPU has begun interrupt sequence.
REQ-012 clear_strobe  input  1  software clear of pending bits.
REQ-013 clear_bits  input  NUM_CHANNELS  bits cleared when clear_strobe=1.
REQ-014 irq_req  output  1  request to CPU microcode.
REQ-015 irq_vector  output  VEC_W  index of requested channel, stable while irq_req=1.
REQ-016 pending  output  NUM_CHANNELS  pending flags, readable as status.

Function
REQ-017 SHALL register irq_in into irq_prev each cycle; edge channel set event = irq_in & ~irq_prev; level channel set event = irq_in.
REQ-018 SHALL set pending[i] on set event regardless of irq_mask (masking gates requests only).
REQ-019 SHALL clear pending[i] when clear_strobe=1 and clear_bits[i]=1, or when irq_ack=1 in REQUEST and i=latched vector.
REQ-020 SHALL give set priority over clear for the same bit in the same cycle.
REQ-021 SHALL select candidate = lowest index i with pending[i] & irq_mask[i]; index 0 highest priority.
REQ-022 SHALL implement FSM IDLE, REQUEST, HOLDOFF.
REQ-023 IDLE -> REQUEST when interrupt_enable=1 and candidate exists; latch candidate into irq_vector on that edge.
REQ-024 REQUEST: irq_req=1, irq_vector frozen even if higher-priority channel becomes pending.
REQ-025 REQUEST -> HOLDOFF on irq_ack; load holdoff counter with HOLDOFF_CYCLES.
REQ-026 REQUEST -> IDLE without clearing pending if interrupt_enable=0, or latched channel is masked or cleared by software, with no irq_ack that cycle; irq_ack takes precedence.
REQ-027 HOLDOFF: decrement counter each cycle, -> IDLE when counter reaches 1; HOLDOFF_CYCLES=0 SHALL go directly REQUEST -> IDLE.
REQ-028 irq_ack outside REQUEST SHALL be ignored.
REQ-029 Latency: edge on irq_in at cycle N -> pending at N+1 -> irq_req at N+2 (IDLE, enabled, unmasked).
REQ-030 irq_req SHALL be a registered output, 0 in IDLE and HOLDOFF.

Reset
REQ-031 On reset: state IDLE, pending=0, irq_prev=0, irq_req=0, irq_vector=0, holdoff counter=0.
REQ-032 Reset mid-REQUEST SHALL drop irq_req next cycle and discard the latched vector; sources high during reset SHALL raise level pending and edge pending only on a later 0->1 after reset.

Structure
REQ-033 FSM state enum (irq_state) SHALL live in the shared types package beside the other CPU enums.
REQ-034 The priority encoder SHALL be a sub-module priority_encoder (parameter WIDTH, outputs index and valid), combinational.
REQ-035 With NUM_CHANNELS=15, irq_vector SHALL feed the CPU immediate path unchanged (CPU applies its own +1 vector offset).

Verification
REQ-036 Reset, irq_mask=all ones, enable=1, pulse irq_in[3] at cycle 10 -> pending=0x0008 at 11, irq_req=1, irq_vector=3 at 12.
REQ-037 Pending bits 5 and 2 simultaneous -> vector 2; ack -> pending=0x0020, irq_req=0 for 2 holdoff cycles, then vector 5.
REQ-038 Pending bit 7 with irq_mask[7]=0 -> no irq_req; set irq_mask[7]=1 -> irq_req within 1 cycle, vector 7.
REQ-039 In REQUEST for vector 4, drop interrupt_enable without ack -> IDLE, pending[4] still 1; re-enable -> request vector 4 again.
REQ-040 irq_ack on vector 1 same cycle as new edge on irq_in[1] -> pending[1] stays 1; level channel 6 held high -> re-requests after each holdoff.
REQ-041 Assert reset during REQUEST -> irq_req=0 and pending=0 next cycle; edge channel held high through reset -> no request until re-edge.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// Shared CPU-side types: interrupt sequencer states and width helper.
package interrupt_controller_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_REQUEST,
        IRQ_HOLDOFF
    } irq_state;

    // Index width for n sources; never narrower than one bit.
    function automatic int vec_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/interrupt_controller_priority_encoder.sv
// Combinational lowest-index-wins priority encoder.
module priority_encoder
    import interrupt_controller_pkg::*;
#(
    parameter int WIDTH   = 15,
    parameter int INDEX_W = vec_width(WIDTH)
) (
    input  logic [WIDTH-1:0]   req,
    output logic [INDEX_W-1:0] index,
    output logic               valid
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        index = '0;
        valid = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = i[INDEX_W-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: pending latch, priority selection and request/holdoff
// sequencer feeding the CPU microcode.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int                    NUM_CHANNELS   = 15,
    parameter logic [NUM_CHANNELS-1:0] EDGE_MASK    = '1,
    parameter int                    HOLDOFF_CYCLES = 2,
    localparam int                   VEC_W          = vec_width(NUM_CHANNELS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CHANNELS-1:0] irq_in,
    input  logic [NUM_CHANNELS-1:0] irq_mask,
    input  logic                    interrupt_enable,
    input  logic                    irq_ack,
    input  logic                    clear_strobe,
    input  logic [NUM_CHANNELS-1:0] clear_bits,
    output logic                    irq_req,
    output logic [VEC_W-1:0]        irq_vector,
    output logic [NUM_CHANNELS-1:0] pending
);

    localparam int CNT_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

    irq_state                  state_reg, state_next;
    logic [NUM_CHANNELS-1:0]   irq_prev_reg;
    logic [NUM_CHANNELS-1:0]   rst_high_reg;
    logic [NUM_CHANNELS-1:0]   pending_reg, pending_next;
    logic [NUM_CHANNELS-1:0]   set_event;
    logic [NUM_CHANNELS-1:0]   clear_mask;
    logic                      irq_req_reg, irq_req_next;
    logic [VEC_W-1:0]          vector_reg, vector_next;
    logic [CNT_W-1:0]          holdoff_reg, holdoff_next;
    logic [VEC_W-1:0]          cand_index;
    logic                      cand_valid;
    logic                      ack_taken;

    // A source already high when reset releases counts as seen, so edge
    // channels need a fresh 0->1 before they can set pending.
    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_set
            if (EDGE_MASK[gi]) begin : g_edge
                assign set_event[gi] = irq_in[gi] & ~irq_prev_reg[gi] & ~rst_high_reg[gi];
            end else begin : g_level
                assign set_event[gi] = irq_in[gi];
            end
        end
    endgenerate

    assign ack_taken = irq_ack && (state_reg == IRQ_REQUEST);

    always_comb begin
        clear_mask = clear_strobe ? clear_bits : '0;
        if (ack_taken) begin
            clear_mask[vector_reg] = 1'b1;
        end
        pending_next = (pending_reg & ~clear_mask) | set_event;
    end

    priority_encoder #(
        .WIDTH   (NUM_CHANNELS),
        .INDEX_W (VEC_W)
    ) u_prio (
        .req   (pending_reg & irq_mask),
        .index (cand_index),
        .valid (cand_valid)
    );

    always_comb begin
        state_next   = state_reg;
        vector_next  = vector_reg;
        holdoff_next = holdoff_reg;
        irq_req_next = 1'b0;
        case (state_reg)
            IRQ_IDLE: begin
                if (interrupt_enable && cand_valid) begin
                    state_next   = IRQ_REQUEST;
                    vector_next  = cand_index;
                    irq_req_next = 1'b1;
                end
            end
            IRQ_REQUEST: begin
                irq_req_next = 1'b1;
                if (irq_ack) begin
                    irq_req_next = 1'b0;
                    if (HOLDOFF_CYCLES == 0) begin
                        state_next = IRQ_IDLE;
                    end else begin
                        state_next   = IRQ_HOLDOFF;
                        holdoff_next = CNT_W'(HOLDOFF_CYCLES);
                    end
                end else if (!interrupt_enable || !irq_mask[vector_reg]
                             || !pending_next[vector_reg]) begin
                    // Withdraw without consuming the pending bit.
                    irq_req_next = 1'b0;
                    state_next   = IRQ_IDLE;
                end
            end
            IRQ_HOLDOFF: begin
                holdoff_next = (holdoff_reg == '0) ? '0 : holdoff_reg - CNT_W'(1);
                if (holdoff_reg <= CNT_W'(1)) begin
                    state_next = IRQ_IDLE;
                end
            end
            default: state_next = IRQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IRQ_IDLE;
            pending_reg  <= '0;
            irq_prev_reg <= '0;
            irq_req_reg  <= 1'b0;
            vector_reg   <= '0;
            holdoff_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            pending_reg  <= pending_next;
            irq_prev_reg <= irq_in;
            irq_req_reg  <= irq_req_next;
            vector_reg   <= vector_next;
            holdoff_reg  <= holdoff_next;
        end
    end

    always_ff @(posedge clk) begin
        rst_high_reg <= reset ? irq_in : '0;
    end

    assign irq_req    = irq_req_reg;
    assign irq_vector = vector_reg;
    assign pending    = pending_reg;

endmodule
